// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues pipelined doubleword reads, splits each into
// big-endian 32-bit instructions and presents them in order through a small FIFO.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          MEM_LAT  = 1,
    parameter logic [0:63] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [0:63] redirectPC,
    output logic        memReq,
    output logic [0:60] memAddr,
    input  logic [0:63] memData,
    output logic        instValid,
    input  logic        instReady,
    output logic [0:31] inst,
    output logic [0:63] instPC
);

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_D = (CW+1)'(DEPTH);

    logic [0:63]        fetchPC;
    logic [CW-1:0]      count;
    logic [CW-1:0]      reserved;
    logic [PW-1:0]      rdPtr;
    logic [PW-1:0]      wrPtr;
    logic [PW-1:0]      wrPtrOdd;
    logic [0:31]        instMem [DEPTH];
    logic [0:63]        pcMem   [DEPTH];

    logic [MEM_LAT-1:0] pipeValid;
    logic [MEM_LAT-1:0] pipeTwo;
    logic [0:63]        pipePC  [MEM_LAT];

    logic               push;
    logic               pop;
    logic               tailTwo;
    logic [0:63]        tailPC;
    logic [CW-1:0]      issueN;
    logic [CW-1:0]      issueAmt;
    logic [CW-1:0]      pushAmt;
    logic [CW-1:0]      popAmt;
    logic [CW:0]        demand;
    logic               unusedBits;

    // Credit check counts the head entry as still occupied even if it pops this cycle.
    always_comb begin
        issueN    = fetchPC[61] ? CW'(1) : CW'(2);
        demand    = {1'b0, count} + {1'b0, reserved} + {1'b0, issueN};
        memReq    = !rst && !redirect && (demand <= DEPTH_D);
        memAddr   = fetchPC[0:60];
        issueAmt  = memReq ? issueN : '0;

        tailTwo   = pipeTwo[MEM_LAT-1];
        tailPC    = pipePC[MEM_LAT-1];
        push      = pipeValid[MEM_LAT-1] && !redirect;
        pushAmt   = push ? (tailTwo ? CW'(2) : CW'(1)) : '0;
        wrPtrOdd  = wrPtr + 1'b1;

        instValid = (count != '0) && !redirect;
        pop       = instValid && instReady;
        popAmt    = pop ? CW'(1) : '0;
        inst      = (count != '0) ? instMem[rdPtr] : '0;
        instPC    = (count != '0) ? pcMem[rdPtr]   : '0;

        unusedBits = ^redirectPC[62:63];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPC  <= RESET_PC;
            count    <= '0;
            reserved <= '0;
            rdPtr    <= '0;
            wrPtr    <= '0;
        end else if (redirect) begin
            fetchPC  <= {redirectPC[0:61], 2'b00};
            count    <= '0;
            reserved <= '0;
            rdPtr    <= '0;
            wrPtr    <= '0;
        end else begin
            if (memReq) begin
                fetchPC <= {fetchPC[0:60] + 61'd1, 3'b000};
            end
            count    <= count + pushAmt - popAmt;
            reserved <= reserved + issueAmt - pushAmt;
            wrPtr    <= wrPtr + PW'(pushAmt);
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

    // Only the valid bits are flushed; stale data behind them is never consumed.
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            pipeValid <= '0;
        end else begin
            pipeValid[0] <= memReq;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipeValid[i] <= pipeValid[i-1];
            end
        end
    end

    // NOTE: data-only storage carries no reset; count and the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        pipeTwo[0] <= !fetchPC[61];
        pipePC[0]  <= fetchPC;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipeTwo[i] <= pipeTwo[i-1];
            pipePC[i]  <= pipePC[i-1];
        end
    end

    // An even-aligned fetch writes two entries, even word first; an odd one writes only the odd word.
    always_ff @(posedge clk) begin
        if (push) begin
            if (tailTwo) begin
                instMem[wrPtr]    <= memData[0:31];
                pcMem[wrPtr]      <= tailPC;
                instMem[wrPtrOdd] <= memData[32:63];
                pcMem[wrPtrOdd]   <= {tailPC[0:60], 3'b100};
            end else begin
                instMem[wrPtr]    <= memData[32:63];
                pcMem[wrPtr]      <= tailPC;
            end
        end
    end

    countBound: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_C);

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: one instance at MEM_LAT=1, one at MEM_LAT=3,
// each with its own memory model, expected-instruction queue and monitor.
module tb_fetch_queue;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef struct {
        logic [0:63] pc;
        logic [0:31] inst;
    } expEntry_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int nChecks = 0;
    int nPass   = 0;

    expEntry_t sbA[$];
    expEntry_t sbB[$];
    int        popCycA[$];

    logic        rstA, redirectA, memReqA, instValidA, instReadyA;
    logic [0:63] redirectPCA, memDataA, instPCA;
    logic [0:60] memAddrA;
    logic [0:31] instA;

    logic        rstB, redirectB, memReqB, instValidB, instReadyB;
    logic [0:63] redirectPCB, memDataB, instPCB;
    logic [0:60] memAddrB;
    logic [0:31] instB;

    fetch_queue #(.DEPTH(4), .MEM_LAT(LAT_A), .RESET_PC(64'd0)) dutA (
        .clk(clk), .rst(rstA), .redirect(redirectA), .redirectPC(redirectPCA),
        .memReq(memReqA), .memAddr(memAddrA), .memData(memDataA),
        .instValid(instValidA), .instReady(instReadyA), .inst(instA), .instPC(instPCA)
    );

    fetch_queue #(.DEPTH(4), .MEM_LAT(LAT_B), .RESET_PC(64'd0)) dutB (
        .clk(clk), .rst(rstB), .redirect(redirectB), .redirectPC(redirectPCB),
        .memReq(memReqB), .memAddr(memAddrB), .memData(memDataB),
        .instValid(instValidB), .instReady(instReadyB), .inst(instB), .instPC(instPCB)
    );

    // Doublewords 0 and 1 hold the program; elsewhere each word encodes its address.
    function automatic logic [0:63] memDword(input logic [0:60] a);
        case (a)
            61'd0:   return 64'h38000001_38600048;
            61'd1:   return 64'h44000002_48000000;
            default: return {4'h1, a[33:60], 4'h2, a[33:60]};
        endcase
    endfunction

    // Memory answers at the negedge so data is stable for the whole response cycle.
    logic [0:60] histA [LAT_A+1] = '{default: '0};
    logic [0:60] histB [LAT_B+1] = '{default: '0};

    always @(negedge clk) begin
        for (int i = LAT_A; i > 0; i--) histA[i] = histA[i-1];
        histA[0] = memAddrA;
        memDataA = memDword(histA[LAT_A]);
    end

    always @(negedge clk) begin
        for (int i = LAT_B; i > 0; i--) histB[i] = histB[i-1];
        histB[0] = memAddrB;
        memDataB = memDword(histB[LAT_B]);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    always @(negedge clk) begin : monitorA
        expEntry_t e;
        if (instValidA && instReadyA) begin
            if (sbA.size() == 0) begin
                nChecks++;
                $display("FAIL A unexpected instruction: got PC %h inst %h, none required", instPCA, instA);
            end else begin
                e = sbA.pop_front();
                check("A instPC", instPCA, e.pc);
                check("A inst", instA, e.inst);
                popCycA.push_back(cycle);
            end
        end
    end

    always @(negedge clk) begin : monitorB
        expEntry_t e;
        if (instValidB && instReadyB) begin
            if (sbB.size() == 0) begin
                nChecks++;
                $display("FAIL B unexpected instruction: got PC %h inst %h, none required", instPCB, instB);
            end else begin
                e = sbB.pop_front();
                check("B instPC", instPCB, e.pc);
                check("B inst", instB, e.inst);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectA(input logic [0:63] pc, input logic [0:31] w);
        expEntry_t e;
        e.pc   = pc;
        e.inst = w;
        sbA.push_back(e);
    endtask

    task automatic expectB(input logic [0:63] pc, input logic [0:31] w);
        expEntry_t e;
        e.pc   = pc;
        e.inst = w;
        sbB.push_back(e);
    endtask

    // Consume until every expected entry has been seen, then stop before the next pop.
    task automatic drainA();
        int budget = 60;
        instReadyA = 1'b1;
        while (sbA.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        instReadyA = 1'b0;
        if (sbA.size() != 0) begin
            nChecks++;
            $display("FAIL A drain timeout: %0d instructions still outstanding, required 0", sbA.size());
            sbA.delete();
        end
    endtask

    task automatic drainB();
        int budget = 60;
        instReadyB = 1'b1;
        while (sbB.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        instReadyB = 1'b0;
        if (sbB.size() != 0) begin
            nChecks++;
            $display("FAIL B drain timeout: %0d instructions still outstanding, required 0", sbB.size());
            sbB.delete();
        end
    endtask

    initial begin
        rstA = 1'b1; redirectA = 1'b0; redirectPCA = '0; instReadyA = 1'b1;
        rstB = 1'b1; redirectB = 1'b0; redirectPCB = '0; instReadyB = 1'b0;

        // Reset, then sequential fetch at full rate.
        expectA(64'h0, 32'h38000001);
        expectA(64'h4, 32'h38600048);
        expectA(64'h8, 32'h44000002);
        expectA(64'hC, 32'h48000000);
        repeat (3) tick();
        check("A reset memReq", memReqA, 0);
        check("A reset instValid", instValidA, 0);
        check("A reset inst", instA, 0);
        check("A reset instPC", instPCA, 0);
        check("B reset memReq", memReqB, 0);
        popCycA.delete();
        rstA = 1'b0;
        #1;
        check("A first memReq", memReqA, 1);
        check("A first memAddr", memAddrA, 0);
        check("A first instValid", instValidA, 0);
        tick();
        check("A second memAddr", memAddrA, 1);
        check("A cycle1 instValid", instValidA, 0);
        tick();
        check("A latency instValid", instValidA, 1);
        check("A latency instPC", instPCA, 64'h0);
        drainA();
        if (popCycA.size() >= 4) begin
            check("A consecutive pops", popCycA[3] - popCycA[0], 3);
        end else begin
            nChecks++;
            $display("FAIL A consecutive pops: got %0d pops, required 4", popCycA.size());
        end

        // Backpressure from reset: FIFO fills, fetch stalls, head holds.
        rstA = 1'b1;
        repeat (2) tick();
        rstA = 1'b0;
        repeat (6) tick();
        check("A full instValid", instValidA, 1);
        check("A full inst", instA, 32'h38000001);
        for (int i = 0; i < 4; i++) begin
            check("A full memReq", memReqA, 0);
            check("A full head PC", instPCA, 64'h0);
            tick();
        end
        expectA(64'h0, 32'h38000001);
        expectA(64'h4, 32'h38600048);
        expectA(64'h8, 32'h44000002);
        expectA(64'hC, 32'h48000000);
        drainA();

        // Redirect to an odd word.
        redirectA = 1'b1; redirectPCA = 64'h16;
        #1;
        check("A redirect instValid", instValidA, 0);
        check("A redirect memReq", memReqA, 0);
        tick();
        redirectA = 1'b0;
        #1;
        check("A odd memReq", memReqA, 1);
        check("A odd memAddr", memAddrA, 2);
        expectA(64'h14, 32'h20000002);
        expectA(64'h18, 32'h10000003);
        drainA();

        // Redirect while two entries are buffered and the consumer is ready.
        redirectA = 1'b1; redirectPCA = 64'h40;
        tick();
        redirectA = 1'b0;
        repeat (2) tick();
        check("A pre-flush instValid", instValidA, 1);
        check("A pre-flush instPC", instPCA, 64'h40);
        redirectA = 1'b1; redirectPCA = 64'h80; instReadyA = 1'b1;
        #1;
        check("A flush-ready instValid", instValidA, 0);
        check("A flush-ready memReq", memReqA, 0);
        tick();
        redirectA = 1'b0;
        #1;
        check("A post-flush instValid", instValidA, 0);
        check("A post-flush memAddr", memAddrA, 61'h10);
        expectA(64'h80, 32'h10000010);
        expectA(64'h84, 32'h20000010);
        drainA();

        // Fetch PC wraps past the top of the address space.
        redirectA = 1'b1; redirectPCA = 64'hFFFF_FFFF_FFFF_FFF8;
        tick();
        redirectA = 1'b0;
        #1;
        check("A wrap memAddr", memAddrA, 61'h1FFF_FFFF_FFFF_FFFF);
        expectA(64'hFFFF_FFFF_FFFF_FFF8, 32'h1FFFFFFF);
        expectA(64'hFFFF_FFFF_FFFF_FFFC, 32'h2FFFFFFF);
        expectA(64'h0, 32'h38000001);
        expectA(64'h4, 32'h38600048);
        drainA();

        // MEM_LAT=3: redirect with two reads in flight; their data must be dropped.
        rstB = 1'b0;
        #1;
        check("B first memAddr", memAddrB, 0);
        tick();
        check("B second memReq", memReqB, 1);
        check("B second memAddr", memAddrB, 1);
        tick();
        check("B credit stall memReq", memReqB, 0);
        check("B in-flight instValid", instValidB, 0);
        redirectB = 1'b1; redirectPCB = 64'h100; instReadyB = 1'b1;
        #1;
        check("B redirect memReq", memReqB, 0);
        check("B redirect instValid", instValidB, 0);
        tick();
        redirectB = 1'b0;
        #1;
        check("B restart memReq", memReqB, 1);
        check("B restart memAddr", memAddrB, 61'h20);
        expectB(64'h100, 32'h10000020);
        expectB(64'h104, 32'h20000020);
        expectB(64'h108, 32'h10000021);
        expectB(64'h10C, 32'h20000021);
        drainB();

        repeat (3) tick();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage that sits directly upstream of the single-cycle PPC execute core.
- Owns the fetch PC and issues doubleword reads on a memory read port.
- Splits each 64-bit doubleword into two 32-bit big-endian instructions and buffers them in a small FIFO.
- Presents one instruction per cycle, with its PC, on a valid/ready handshake. Accepts a redirect (branch target) that flushes all buffered and in-flight fetches.

Parameters:
- DEPTH, 4: instruction FIFO entries. Power of 2, minimum 2.
- MEM_LAT, 1: fixed memory read latency in cycles, 1..3. Reads are fully pipelined.
- RESET_PC, 0: fetch PC after reset. 64 bits, bits [62:63] zero.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- redirect  in  1  flush and restart fetch at redirectPC
- redirectPC  in  [0:63]  new fetch PC; bits [62:63] ignored
- memReq  out  1  read request valid this cycle
- memAddr  out  [0:60]  doubleword address, equal to fetchPC[0:60]
- memData  in  [0:63]  read data, valid exactly MEM_LAT cycles after memReq
- instValid  out  1  head instruction valid
- instReady  in  1  consumer accepts head this cycle
- inst  out  [0:31]  head instruction
- instPC  out  [0:63]  PC of head instruction

Behaviour:
- Reset (rst=1 at clk edge): fetchPC <= RESET_PC; FIFO empty; in-flight pipeline cleared; reserved <= 0. Outputs during and after reset: memReq=0, instValid=0, inst=0, instPC=0 until the first entry exists.
- Word select: fetchPC[61]=0 yields two instructions, memData[0:31] at PC and memData[32:63] at PC+4. fetchPC[61]=1 yields one instruction, memData[32:63].
- Issue:
  - memReq=1 when !rst, !redirect and count + reserved + n <= DEPTH, where n is the number of useful words (1 or 2) and count excludes any same-cycle pop (conservative).
  - On issue: reserved += n; fetchPC <= {fetchPC[0:60]+1, 3'b000}. The 64-bit add wraps to 0.
  - A 1..MEM_LAT-stage shift pipeline carries {valid, n, PC} alongside each request.
- Response:
  - When the pipeline tail is valid, write its n words into the FIFO in order (even word first) and set reserved -= n.
  - Push and issue in the same cycle is legal; reserved nets both changes.
- Output:
  - instValid = (count != 0) & !redirect.
  - inst and instPC come from the head entry.
  - Pop occurs when instValid & instReady.
  - Push and pop in the same cycle: count += pushed - popped.
  - FIFO pointers wrap mod DEPTH. Overflow is impossible by the credit rule. Simulation assertion: count <= DEPTH.
- Redirect (priority over everything except rst):
  - In the redirect cycle: memReq=0, instValid=0, no pop.
  - At the edge: FIFO emptied; all pipeline valid bits cleared, so stale data arriving later is dropped; reserved <= 0; fetchPC <= {redirectPC[0:61], 2'b00}.
  - The first new request issues in the following cycle.
- Back-to-back redirects: each restarts fetch; only the last one takes effect.
- Steady-state latency, MEM_LAT=1, empty FIFO: request at cycle t; instruction visible with instValid=1 at cycle t+MEM_LAT+1.
- Steady-state throughput: 1 instruction/cycle with DEPTH >= 2*(MEM_LAT+1) and instReady held at 1.

Test Plan:
- Reset then sequential fetch:
  - Stimulus: MEM_LAT=1, memory dword0=0x38000001_38600048, dword1=0x44000002_48000000, instReady=1.
  - Required: memAddr=0 in the first cycle after reset drops.
  - Required sequence: (PC 0x0, 0x38000001), (PC 0x4, 0x38600048), (PC 0x8, 0x44000002), (PC 0xC, 0x48000000), on consecutive cycles.
- Backpressure:
  - Stimulus: instReady=0.
  - Required: count reaches 4 (DEPTH); memReq stays 0 afterwards; head stays PC 0x0.
  - Stimulus: raise instReady.
  - Required: PCs 0x0, 0x4, 0x8, 0xC in order, no duplicates or gaps.
- Odd-word redirect:
  - Stimulus: redirect with redirectPC=0x16.
  - Required: fetchPC=0x14; memAddr=2; first instruction (PC 0x14) is memData[32:63]; next is PC 0x18.
- Flush in flight:
  - Stimulus: MEM_LAT=3, two requests outstanding, redirect to 0x100.
  - Required: no instruction with PC < 0x100 is ever presented; first instPC=0x100.
- Redirect with ready:
  - Stimulus: redirect=1 and instReady=1 while count=2.
  - Required: instValid=0 that cycle; no pop; FIFO empty the next cycle.
- Wrap-around:
  - Stimulus: redirect to 0xFFFF_FFFF_FFFF_FFF8.
  - Required: instPC sequence ...FFF8, ...FFFC, 0x0000_0000_0000_0000, 0x4.
